control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit that drives every strobe of the datapath: register in/out enables, MAR/MDR, memory read/write, HI/LO, Y/Z, I/O ports and the gra/grb/grc select lines.
- Sits directly upstream of the datapath and replaces the per-state strobes the benches drive by hand today.
- Runs the fetch sequence, then decodes IR[31:27] into a per-opcode execute step sequence.

Parameters:
- OPC_W, 5, opcode field width (IR[31:27]).
- MEM_WAIT, 1, cycles a memory access step is held (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- ir  in  32  current datapath IR contents; only [31:27] is used.
- pco, pci, incpc  out  1  PC out, PC in, ALU increment-PC mode.
- iri, mari, mdri, mdro  out  1  IR in, MAR in, MDR in, MDR out.
- mem_read, mem_write  out  1  memory strobes.
- hii, hio, loi, loo  out  1  HI/LO register in/out.
- ryi, rzhi, rzli, rzho, rzlo  out  1  Y in, Z high/low in and out.
- csigno  out  1  sign-extended constant onto bus.
- gra, grb, grc, rin, rout, baout  out  1  register-file select and enables.
- ipo, opi  out  1  input port out, output port in.
- alu_op  out  5  ALU operation; valid only while rzli or rzhi is high, 0 otherwise.
- run  out  1  high while executing, low in RESET and HALT.
- step  out  4  current state encoding, for debug.

Behaviour:
- States: RESET, T0–T7, HALT.
- State and wait counter are registered; every output is decoded combinationally from (state, ir[31:27], wait counter).
- clear low (any time):
  - state=RESET asynchronously; all strobes 0, alu_op=0, run=0.
  - An instruction interrupted mid-sequence is abandoned with no partial strobes.
- RESET → T0 on the first rising edge after clear deasserts; run=1 from T0 onward.
- Fetch:
  - T0: pco, mari, incpc, rzli.
  - T1: rzlo, pci, mem_read, mdri.
  - T2: mdro, iri.
- Opcode is sampled from ir in T3 and later states.
- Execute sequences; the final step shown returns to T0 on the next edge:
  - add/sub/and/or (3,4,5,6):
    - T3: grb, rout, ryi.
    - T4: grc, rout, rzli, alu_op=opcode.
    - T5: rzlo, gra, rin.
  - addi/andi/ori (12,13,14):
    - T3: grb, rout, ryi.
    - T4: csigno, rzli, alu_op=opcode.
    - T5: rzlo, gra, rin.
  - ldi (1):
    - T3: grb, baout, ryi.
    - T4: csigno, rzli, alu_op=3.
    - T5: rzlo, gra, rin.
  - ld (0):
    - T3–T4 as ldi.
    - T5: rzlo, mari.
    - T6: mem_read, mdri.
    - T7: mdro, gra, rin.
  - st (2):
    - T3–T5 as ld.
    - T6: gra, rout, mdri.
    - T7: mem_write.
  - mul/div (15,16):
    - T3: gra, rout, ryi.
    - T4: grb, rout, rzhi, rzli, alu_op=opcode.
    - T5: rzlo, loi.
    - T6: rzho, hii.
  - mfhi (24): T3: hio, gra, rin.
  - mflo (25): T3: loo, gra, rin.
  - in (22): T3: ipo, gra, rin.
  - out (23): T3: gra, rout, opi.
  - jr (20): T3: gra, rout, pci.
  - nop (26) and all undefined opcodes: T3 drives no strobes, then T0.
  - halt (27): T3 → HALT. HALT drives all strobes 0, run=0, and is exited only by clear.
- Memory steps (fetch T1, ld T6, st T7):
  - The state holds for MEM_WAIT cycles; mem_read or mem_write stays high throughout.
  - mdri and pci assert only in the final cycle of the hold.
  - The wait counter resets to 0 on every state change and on clear.
- At most one bus driver (…o/rout/baout/csigno/ipo) is high in any state; this is an assertion target.

Decomposition:
- cpu_pkg holds the opcode localparams (LD…HALT), the state encodings, and ALU_ADD=3.
- Sub-module control_decode is purely combinational: (state, opcode, last_wait) → strobe vector.
- control_sequencer holds the state register and the wait counter.

Test Plan:
- Reset then run:
  - clear low for 2 cycles, release → all strobes 0 during reset.
  - First edge: step=T0, with pco=mari=incpc=rzli=1, run=1.
- and, ir=0x28918000 (opcode 5):
  - T3: grb, rout, ryi.
  - T4: grc, rout, rzli, alu_op=5.
  - T5: rzlo, gra, rin.
  - Next state is T0.
- mfhi, ir=0xC1000000:
  - T3: hio=gra=rin=1 only.
  - Next edge returns to T0; total instruction time is 4 cycles.
- ld with MEM_WAIT=3:
  - T6 lasts 3 cycles with mem_read=1 throughout.
  - mdri=1 only in cycle 3.
  - T7: mdro, gra, rin.
- Reset mid-op: clear low during T4 of ld → all outputs 0 in the same cycle (async), step=RESET; after release, T0.
- halt, ir=0xD8000000: HALT after T3; run=0 and all strobes 0 for 20 cycles; only clear restarts.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the hardwired control unit: opcodes, step encodings and
// the strobe vector handed from the decoder to the sequencer outputs.
package cpu_pkg;

    localparam int unsigned IR_W   = 32;
    localparam int unsigned OPC_W  = 5;
    localparam int unsigned ALU_W  = 5;
    localparam int unsigned STEP_W = 4;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_LD   = 5'd0;
    localparam opcode_t OP_LDI  = 5'd1;
    localparam opcode_t OP_ST   = 5'd2;
    localparam opcode_t OP_ADD  = 5'd3;
    localparam opcode_t OP_SUB  = 5'd4;
    localparam opcode_t OP_AND  = 5'd5;
    localparam opcode_t OP_OR   = 5'd6;
    localparam opcode_t OP_ADDI = 5'd12;
    localparam opcode_t OP_ANDI = 5'd13;
    localparam opcode_t OP_ORI  = 5'd14;
    localparam opcode_t OP_MUL  = 5'd15;
    localparam opcode_t OP_DIV  = 5'd16;
    localparam opcode_t OP_JR   = 5'd20;
    localparam opcode_t OP_IN   = 5'd22;
    localparam opcode_t OP_OUT  = 5'd23;
    localparam opcode_t OP_MFHI = 5'd24;
    localparam opcode_t OP_MFLO = 5'd25;
    localparam opcode_t OP_NOP  = 5'd26;
    localparam opcode_t OP_HALT = 5'd27;

    localparam logic [ALU_W-1:0] ALU_ADD = 5'd3;

    typedef enum logic [STEP_W-1:0] {
        S_T0    = 4'd0,
        S_T1    = 4'd1,
        S_T2    = 4'd2,
        S_T3    = 4'd3,
        S_T4    = 4'd4,
        S_T5    = 4'd5,
        S_T6    = 4'd6,
        S_T7    = 4'd7,
        S_RESET = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    typedef struct packed {
        logic             pco;
        logic             pci;
        logic             incpc;
        logic             iri;
        logic             mari;
        logic             mdri;
        logic             mdro;
        logic             mem_read;
        logic             mem_write;
        logic             hii;
        logic             hio;
        logic             loi;
        logic             loo;
        logic             ryi;
        logic             rzhi;
        logic             rzli;
        logic             rzho;
        logic             rzlo;
        logic             csigno;
        logic             gra;
        logic             grb;
        logic             grc;
        logic             rin;
        logic             rout;
        logic             baout;
        logic             ipo;
        logic             opi;
        logic [ALU_W-1:0] alu_op;
    } strobes_t;

    // Steps that hold for the memory wait: fetch read, ld read, st write.
    function automatic logic is_mem_step(state_t st, opcode_t op);
        return (st == S_T1) || ((st == S_T6) && (op == OP_LD)) ||
               ((st == S_T7) && (op == OP_ST));
    endfunction

    // Final execute step of each opcode; the step after it is T0.
    function automatic state_t last_step(opcode_t op);
        state_t st;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: st = S_T5;
            OP_LD, OP_ST:                     st = S_T7;
            OP_MUL, OP_DIV:                   st = S_T6;
            default:                          st = S_T3;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between sequencer (master) and datapath (slave): IR feedback
// plus every datapath strobe, ALU op, run flag and debug step.
interface control_sequencer_if;
    import cpu_pkg::*;

    logic [IR_W-1:0]   ir;
    logic              pco, pci, incpc;
    logic              iri, mari, mdri, mdro;
    logic              mem_read, mem_write;
    logic              hii, hio, loi, loo;
    logic              ryi, rzhi, rzli, rzho, rzlo;
    logic              csigno;
    logic              gra, grb, grc, rin, rout, baout;
    logic              ipo, opi;
    logic [ALU_W-1:0]  alu_op;
    logic              run;
    logic [STEP_W-1:0] step;

    modport master (
        input  ir,
        output pco, pci, incpc, iri, mari, mdri, mdro, mem_read, mem_write,
               hii, hio, loi, loo, ryi, rzhi, rzli, rzho, rzlo, csigno,
               gra, grb, grc, rin, rout, baout, ipo, opi, alu_op, run, step
    );

    modport slave (
        output ir,
        input  pco, pci, incpc, iri, mari, mdri, mdro, mem_read, mem_write,
               hii, hio, loi, loo, ryi, rzhi, rzli, rzho, rzlo, csigno,
               gra, grb, grc, rin, rout, baout, ipo, opi, alu_op, run, step
    );

endinterface

// File: rtl/control_decode.sv
// Combinational strobe decoder.
//   state     : current sequencer step
//   opcode    : IR[31:27], meaningful from T3 onward
//   last_wait : final cycle of a memory hold (gates pci/mdri)
//   strobes_c : full strobe vector including alu_op
module control_decode
    import cpu_pkg::*;
(
    input  state_t   state,
    input  opcode_t  opcode,
    input  logic     last_wait,
    output strobes_t strobes_c
);

    always_comb begin
        strobes_c = '0;
        case (state)
            S_T0: begin
                strobes_c.pco   = 1'b1;
                strobes_c.mari  = 1'b1;
                strobes_c.incpc = 1'b1;
                strobes_c.rzli  = 1'b1;
            end
            S_T1: begin
                strobes_c.rzlo     = 1'b1;
                strobes_c.mem_read = 1'b1;
                strobes_c.pci      = last_wait;
                strobes_c.mdri     = last_wait;
            end
            S_T2: begin
                strobes_c.mdro = 1'b1;
                strobes_c.iri  = 1'b1;
            end
            S_T3: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                        strobes_c.grb  = 1'b1;
                        strobes_c.rout = 1'b1;
                        strobes_c.ryi  = 1'b1;
                    end
                    OP_LD, OP_LDI, OP_ST: begin
                        strobes_c.grb   = 1'b1;
                        strobes_c.baout = 1'b1;
                        strobes_c.ryi   = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        strobes_c.gra  = 1'b1;
                        strobes_c.rout = 1'b1;
                        strobes_c.ryi  = 1'b1;
                    end
                    OP_MFHI: begin
                        strobes_c.hio = 1'b1;
                        strobes_c.gra = 1'b1;
                        strobes_c.rin = 1'b1;
                    end
                    OP_MFLO: begin
                        strobes_c.loo = 1'b1;
                        strobes_c.gra = 1'b1;
                        strobes_c.rin = 1'b1;
                    end
                    OP_IN: begin
                        strobes_c.ipo = 1'b1;
                        strobes_c.gra = 1'b1;
                        strobes_c.rin = 1'b1;
                    end
                    OP_OUT: begin
                        strobes_c.gra  = 1'b1;
                        strobes_c.rout = 1'b1;
                        strobes_c.opi  = 1'b1;
                    end
                    OP_JR: begin
                        strobes_c.gra  = 1'b1;
                        strobes_c.rout = 1'b1;
                        strobes_c.pci  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        strobes_c.grc    = 1'b1;
                        strobes_c.rout   = 1'b1;
                        strobes_c.rzli   = 1'b1;
                        strobes_c.alu_op = opcode;
                    end
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        strobes_c.csigno = 1'b1;
                        strobes_c.rzli   = 1'b1;
                        strobes_c.alu_op = opcode;
                    end
                    OP_LD, OP_LDI, OP_ST: begin
                        strobes_c.csigno = 1'b1;
                        strobes_c.rzli   = 1'b1;
                        strobes_c.alu_op = ALU_ADD;
                    end
                    OP_MUL, OP_DIV: begin
                        strobes_c.grb    = 1'b1;
                        strobes_c.rout   = 1'b1;
                        strobes_c.rzhi   = 1'b1;
                        strobes_c.rzli   = 1'b1;
                        strobes_c.alu_op = opcode;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
                        strobes_c.rzlo = 1'b1;
                        strobes_c.gra  = 1'b1;
                        strobes_c.rin  = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        strobes_c.rzlo = 1'b1;
                        strobes_c.mari = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        strobes_c.rzlo = 1'b1;
                        strobes_c.loi  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (opcode)
                    OP_LD: begin
                        strobes_c.mem_read = 1'b1;
                        strobes_c.mdri     = last_wait;
                    end
                    OP_ST: begin
                        strobes_c.gra  = 1'b1;
                        strobes_c.rout = 1'b1;
                        strobes_c.mdri = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        strobes_c.rzho = 1'b1;
                        strobes_c.hii  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (opcode)
                    OP_LD: begin
                        strobes_c.mdro = 1'b1;
                        strobes_c.gra  = 1'b1;
                        strobes_c.rin  = 1'b1;
                    end
                    OP_ST:   strobes_c.mem_write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, opcode-driven execute T3-T7, HALT.
//   clock : rising-edge clock
//   clear : asynchronous active-low reset (forces RESET, all strobes 0)
//   bus   : control_sequencer_if master (ir in; strobes, alu_op, run, step out)
// Outputs are decoded combinationally from (state, opcode, wait counter).
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic                 clock,
    input  logic                 clear,
    control_sequencer_if.master  bus
);

    localparam int unsigned WAIT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    opcode_t             opcode;
    logic                last_wait;
    strobes_t            strobes_c;
    logic                unused_ir;

    assign opcode    = bus.ir[IR_W-1 -: OPC_W];
    assign unused_ir = ^bus.ir[IR_W-OPC_W-1:0];
    assign last_wait = (wait_cnt == WAIT_W'(MEM_WAIT - 1));

    // State and memory-hold counter.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= S_RESET;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next step: memory steps hold until the counter reaches its last cycle.
    always_comb begin
        state_nxt = state;
        wait_nxt  = '0;
        if (is_mem_step(state, opcode) && !last_wait) begin
            wait_nxt = wait_cnt + WAIT_W'(1);
        end else begin
            case (state)
                S_RESET:          state_nxt = S_T0;
                S_T0, S_T1, S_T2: state_nxt = state_t'(state + STEP_W'(1));
                S_HALT:           state_nxt = S_HALT;
                default: begin
                    if ((state == S_T3) && (opcode == OP_HALT))
                        state_nxt = S_HALT;
                    else if (state == last_step(opcode))
                        state_nxt = S_T0;
                    else
                        state_nxt = state_t'(state + STEP_W'(1));
                end
            endcase
        end
    end

    control_decode u_decode (
        .state     (state),
        .opcode    (opcode),
        .last_wait (last_wait),
        .strobes_c (strobes_c)
    );

    assign bus.pco       = strobes_c.pco;
    assign bus.pci       = strobes_c.pci;
    assign bus.incpc     = strobes_c.incpc;
    assign bus.iri       = strobes_c.iri;
    assign bus.mari      = strobes_c.mari;
    assign bus.mdri      = strobes_c.mdri;
    assign bus.mdro      = strobes_c.mdro;
    assign bus.mem_read  = strobes_c.mem_read;
    assign bus.mem_write = strobes_c.mem_write;
    assign bus.hii       = strobes_c.hii;
    assign bus.hio       = strobes_c.hio;
    assign bus.loi       = strobes_c.loi;
    assign bus.loo       = strobes_c.loo;
    assign bus.ryi       = strobes_c.ryi;
    assign bus.rzhi      = strobes_c.rzhi;
    assign bus.rzli      = strobes_c.rzli;
    assign bus.rzho      = strobes_c.rzho;
    assign bus.rzlo      = strobes_c.rzlo;
    assign bus.csigno    = strobes_c.csigno;
    assign bus.gra       = strobes_c.gra;
    assign bus.grb       = strobes_c.grb;
    assign bus.grc       = strobes_c.grc;
    assign bus.rin       = strobes_c.rin;
    assign bus.rout      = strobes_c.rout;
    assign bus.baout     = strobes_c.baout;
    assign bus.ipo       = strobes_c.ipo;
    assign bus.opi       = strobes_c.opi;
    assign bus.alu_op    = strobes_c.alu_op;
    assign bus.run       = (state != S_RESET) && (state != S_HALT);
    assign bus.step      = STEP_W'(state);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer with a 3-cycle memory hold.
module tb_control_sequencer;
    import cpu_pkg::*;

    localparam int unsigned MW = 3;

    typedef struct {
        string            name;
        logic [STEP_W-1:0] step;
        logic             run;
        strobes_t         s;
    } exp_t;

    logic clock;
    logic clear;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    control_sequencer_if bus();

    control_sequencer #(.MEM_WAIT(MW)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    strobes_t act;
    assign act = strobes_t'{pco: bus.pco, pci: bus.pci, incpc: bus.incpc,
        iri: bus.iri, mari: bus.mari, mdri: bus.mdri, mdro: bus.mdro,
        mem_read: bus.mem_read, mem_write: bus.mem_write, hii: bus.hii,
        hio: bus.hio, loi: bus.loi, loo: bus.loo, ryi: bus.ryi,
        rzhi: bus.rzhi, rzli: bus.rzli, rzho: bus.rzho, rzlo: bus.rzlo,
        csigno: bus.csigno, gra: bus.gra, grb: bus.grb, grc: bus.grc,
        rin: bus.rin, rout: bus.rout, baout: bus.baout, ipo: bus.ipo,
        opi: bus.opi, alu_op: bus.alu_op};

    localparam strobes_t Z = '0;

    // Push the expectation for the current cycle, then advance one clock.
    task automatic push(input string name, input state_t st, input strobes_t s);
        exp_t e;
        e.name = name;
        e.step = STEP_W'(st);
        e.run  = (st != S_RESET) && (st != S_HALT);
        e.s    = s;
        sb.push_back(e);
    endtask

    task automatic tick(input string name, input state_t st, input strobes_t s);
        push(name, st, s);
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input string n);
        tick({n, ".T0"}, S_T0, strobes_t'{pco: 1'b1, mari: 1'b1, incpc: 1'b1, rzli: 1'b1, default: '0});
        for (int i = 0; i < int'(MW) - 1; i++)
            tick({n, ".T1hold"}, S_T1, strobes_t'{rzlo: 1'b1, mem_read: 1'b1, default: '0});
        tick({n, ".T1last"}, S_T1, strobes_t'{rzlo: 1'b1, mem_read: 1'b1, pci: 1'b1, mdri: 1'b1, default: '0});
        tick({n, ".T2"}, S_T2, strobes_t'{mdro: 1'b1, iri: 1'b1, default: '0});
    endtask

    // Monitor: compares on every falling clock edge and on an async clear.
    initial begin
        exp_t e;
        #2;
        forever begin
            @(negedge clock or negedge clear);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++;
                if (bus.step !== e.step || bus.run !== e.run || act !== e.s) begin
                    n_fail++;
                    $display("FAIL %s: step %0d run %0b strobes %h, required step %0d run %0b strobes %h",
                             e.name, bus.step, bus.run, act, e.step, e.run, e.s);
                end
                n_tests++;
                if ($countones({bus.pco, bus.mdro, bus.hio, bus.loo, bus.rzho, bus.rzlo,
                                bus.rout, bus.baout, bus.csigno, bus.ipo}) > 1) begin
                    n_fail++;
                    $display("FAIL %s.bus_drivers: strobes %h, required at most one driver",
                             e.name, act);
                end
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear   = 1'b0;
        bus.ir  = 32'h0;
        @(posedge clock);
        #1;

        // Reset held, then released: first edge afterwards enters T0.
        tick("reset0", S_RESET, Z);
        tick("reset1", S_RESET, Z);
        clear = 1'b1;
        tick("release", S_RESET, Z);

        // and r?, opcode 5
        bus.ir = 32'h2891_8000;
        fetch("and");
        tick("and.T3", S_T3, strobes_t'{grb: 1'b1, rout: 1'b1, ryi: 1'b1, default: '0});
        tick("and.T4", S_T4, strobes_t'{grc: 1'b1, rout: 1'b1, rzli: 1'b1, alu_op: 5'd5, default: '0});
        tick("and.T5", S_T5, strobes_t'{rzlo: 1'b1, gra: 1'b1, rin: 1'b1, default: '0});

        // mfhi, opcode 24: single execute step
        bus.ir = 32'hC100_0000;
        fetch("mfhi");
        tick("mfhi.T3", S_T3, strobes_t'{hio: 1'b1, gra: 1'b1, rin: 1'b1, default: '0});

        // addi, opcode 12
        bus.ir = 32'h6000_0000;
        fetch("addi");
        tick("addi.T3", S_T3, strobes_t'{grb: 1'b1, rout: 1'b1, ryi: 1'b1, default: '0});
        tick("addi.T4", S_T4, strobes_t'{csigno: 1'b1, rzli: 1'b1, alu_op: 5'd12, default: '0});
        tick("addi.T5", S_T5, strobes_t'{rzlo: 1'b1, gra: 1'b1, rin: 1'b1, default: '0});

        // mul, opcode 15: T6 is not a memory step, no hold
        bus.ir = 32'h7800_0000;
        fetch("mul");
        tick("mul.T3", S_T3, strobes_t'{gra: 1'b1, rout: 1'b1, ryi: 1'b1, default: '0});
        tick("mul.T4", S_T4, strobes_t'{grb: 1'b1, rout: 1'b1, rzhi: 1'b1, rzli: 1'b1, alu_op: 5'd15, default: '0});
        tick("mul.T5", S_T5, strobes_t'{rzlo: 1'b1, loi: 1'b1, default: '0});
        tick("mul.T6", S_T6, strobes_t'{rzho: 1'b1, hii: 1'b1, default: '0});

        // st, opcode 2: T7 write held for the memory wait
        bus.ir = 32'h1000_0000;
        fetch("st");
        tick("st.T3", S_T3, strobes_t'{grb: 1'b1, baout: 1'b1, ryi: 1'b1, default: '0});
        tick("st.T4", S_T4, strobes_t'{csigno: 1'b1, rzli: 1'b1, alu_op: 5'd3, default: '0});
        tick("st.T5", S_T5, strobes_t'{rzlo: 1'b1, mari: 1'b1, default: '0});
        tick("st.T6", S_T6, strobes_t'{gra: 1'b1, rout: 1'b1, mdri: 1'b1, default: '0});
        for (int i = 0; i < int'(MW); i++)
            tick("st.T7", S_T7, strobes_t'{mem_write: 1'b1, default: '0});

        // Single-step opcodes: out, jr, in, mflo, nop, undefined (31)
        bus.ir = 32'hB800_0000;
        fetch("out");
        tick("out.T3", S_T3, strobes_t'{gra: 1'b1, rout: 1'b1, opi: 1'b1, default: '0});
        bus.ir = 32'hA000_0000;
        fetch("jr");
        tick("jr.T3", S_T3, strobes_t'{gra: 1'b1, rout: 1'b1, pci: 1'b1, default: '0});
        bus.ir = 32'hB000_0000;
        fetch("in");
        tick("in.T3", S_T3, strobes_t'{ipo: 1'b1, gra: 1'b1, rin: 1'b1, default: '0});
        bus.ir = 32'hC800_0000;
        fetch("mflo");
        tick("mflo.T3", S_T3, strobes_t'{loo: 1'b1, gra: 1'b1, rin: 1'b1, default: '0});
        bus.ir = 32'hD000_0000;
        fetch("nop");
        tick("nop.T3", S_T3, Z);
        bus.ir = 32'hF800_0000;
        fetch("undef");
        tick("undef.T3", S_T3, Z);

        // ld, opcode 0: T6 read held MW cycles, mdri only in the last
        bus.ir = 32'h0000_0000;
        fetch("ld");
        tick("ld.T3", S_T3, strobes_t'{grb: 1'b1, baout: 1'b1, ryi: 1'b1, default: '0});
        tick("ld.T4", S_T4, strobes_t'{csigno: 1'b1, rzli: 1'b1, alu_op: 5'd3, default: '0});
        tick("ld.T5", S_T5, strobes_t'{rzlo: 1'b1, mari: 1'b1, default: '0});
        for (int i = 0; i < int'(MW) - 1; i++)
            tick("ld.T6hold", S_T6, strobes_t'{mem_read: 1'b1, default: '0});
        tick("ld.T6last", S_T6, strobes_t'{mem_read: 1'b1, mdri: 1'b1, default: '0});
        tick("ld.T7", S_T7, strobes_t'{mdro: 1'b1, gra: 1'b1, rin: 1'b1, default: '0});

        // ld abandoned by clear during T4
        fetch("ldabort");
        tick("ldabort.T3", S_T3, strobes_t'{grb: 1'b1, baout: 1'b1, ryi: 1'b1, default: '0});
        push("ldabort.T4", S_T4, strobes_t'{csigno: 1'b1, rzli: 1'b1, alu_op: 5'd3, default: '0});
        @(negedge clock);
        #2;
        clear = 1'b0;
        push("ldabort.async", S_RESET, Z);
        @(posedge clock);
        #1;
        tick("ldabort.held", S_RESET, Z);
        clear = 1'b1;
        tick("ldabort.release", S_RESET, Z);

        // halt, opcode 27: parks in HALT until clear
        bus.ir = 32'hD800_0000;
        fetch("halt");
        tick("halt.T3", S_T3, Z);
        bus.ir = 32'hD000_0000;
        for (int i = 0; i < 20; i++)
            tick("halt.park", S_HALT, Z);
        clear = 1'b0;
        tick("halt.clear", S_RESET, Z);
        clear = 1'b1;
        tick("halt.release", S_RESET, Z);
        tick("halt.restart", S_T0, strobes_t'{pco: 1'b1, mari: 1'b1, incpc: 1'b1, rzli: 1'b1, default: '0});

        for (int i = 0; i < 5 && sb.size() > 0; i++)
            @(posedge clock);
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
